// File: rtl/writeback_pc_unit.sv
// writeback_pc_unit: registered writeback-select and next-PC stage with UART-read stall; optional return-address stack enabled by WBPC_RAS_EN
module writeback_pc_unit #(
  parameter int INST_MEM_WIDTH = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int PC_RESET       = 0,
  parameter int RAS_DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                Branch,
  input  logic                      UARTtoReg,
  input  logic                      ret_hint,
  input  logic [DATA_WIDTH-1:0]     read_data,
  input  logic [DATA_WIDTH-1:0]     register_data,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [4:0]                rd,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  input  logic [INST_MEM_WIDTH-1:0] pc2,
  input  logic                      input_ready,
  input  logic [DATA_WIDTH-1:0]     input_data,
  output logic                      input_ack,
  output logic                      stall,
  output logic                      valid_out,
  output logic                      RegWrite_next,
  output logic [DATA_WIDTH-1:0]     data,
  output logic [4:0]                rd_next,
  output logic [INST_MEM_WIDTH-1:0] pc_generated,
  output logic [INST_MEM_WIDTH-1:0] pc1_next
);
  localparam int W = INST_MEM_WIDTH;
  typedef enum logic {RUN, WAIT_UART} state_t;
  state_t                state_q, state_d;
  logic                  valid_q, valid_d, regwrite_q, regwrite_d, ack_q, ack_d, go;
  logic [DATA_WIDTH-1:0] data_q, data_d, wdata;
  logic [4:0]            rd_q, rd_d;
  logic [W-1:0]          pc_q, pc_d, pc1_q, pc_base, pc_sel;
  logic                  unused_bits;
  assign unused_bits = ^{inst_index[25:W], register_data[DATA_WIDTH-1:W], ret_hint};
  assign stall = (state_q == WAIT_UART) ? !input_ready : (valid_in & UARTtoReg & !input_ready);
  assign go    = valid_in & !stall;
  assign wdata = UARTtoReg ? input_data :
                 (MemtoReg == 2'b00) ? alu_result :
                 (MemtoReg == 2'b01) ? read_data :
                 (MemtoReg == 2'b10) ? DATA_WIDTH'(pc1) : register_data;
  assign pc_base = (Branch == 2'b00) ? pc1 :
                   (Branch == 2'b01) ? pc2 :
                   (Branch == 2'b10) ? inst_index[W-1:0] : register_data[W-1:0];
`ifdef WBPC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic [W-1:0]  ras_q [RAS_DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;
  assign push   = go & (MemtoReg == 2'b10) & (Branch == 2'b10);
  assign pop    = go & (Branch == 2'b11) & ret_hint & (cnt_q != '0);
  assign pc_sel = pop ? ras_q[ptr_q - 1'b1] : pc_base;
  // Circular stack: ptr is the next free slot, so a push when full lands on the oldest entry
  always_comb begin
    ptr_d = push ? ptr_q + 1'b1 : pop ? ptr_q - 1'b1 : ptr_q;
    cnt_d = push ? ((cnt_q == CW'(RAS_DEPTH)) ? cnt_q : cnt_q + 1'b1) : pop ? cnt_q - 1'b1 : cnt_q;
  end
  // Stack pointer and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  // Stack storage needs no reset; occupancy guards reads
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= pc1;
  end
`else
  assign pc_sel = pc_base;
`endif
  // Next-state: stall keeps us waiting; a completed instruction loads the result registers
  always_comb begin
    state_d    = stall ? WAIT_UART : RUN;
    valid_d    = go;
    regwrite_d = go & RegWrite;
    ack_d      = go & UARTtoReg;
    data_d     = go ? wdata : data_q;
    rd_d       = go ? rd : rd_q;
    pc_d       = go ? pc_sel : pc_q;
  end
  // Stage registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
      rd_q       <= '0;
      pc_q       <= W'(PC_RESET);
      pc1_q      <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      pc1_q      <= pc1;
    end
  end
  assign input_ack     = ack_q;
  assign valid_out     = valid_q;
  assign RegWrite_next = regwrite_q;
  assign data          = data_q;
  assign rd_next       = rd_q;
  assign pc_generated  = pc_q;
  assign pc1_next      = pc1_q;
endmodule
